// File: rtl/fair_arbiter.sv
// Four-way round-robin arbiter with registered grants and one IDLE cycle between owners.
// Define FAIR_ARBITER_TIMEOUT_EN to build in the HOLD_MAX timeout preemption.
module fair_arbiter #(
    parameter int HOLD_MAX = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       req_0,
    input  logic       req_1,
    input  logic       req_2,
    input  logic       req_3,
    output logic       gnt_0,
    output logic       gnt_1,
    output logic       gnt_2,
    output logic       gnt_3,
    output logic [1:0] owner,
    output logic       busy,
    output logic       preempt
);
    typedef enum logic [2:0] {
        IDLE = 3'b000,
        GNT0 = 3'b001,
        GNT1 = 3'b010,
        GNT2 = 3'b011,
        GNT3 = 3'b100
    } state_e;

    if (HOLD_MAX < 2 || HOLD_MAX > 15) begin : g_badHoldMax
        $error("fair_arbiter: HOLD_MAX must lie in 2..15");
    end

    // Held as a plain vector so unused encodings stay representable and recoverable.
    logic [2:0] state_q;
    state_e     state_d;
    logic [1:0] lastPtr_q, lastPtr_d;
    logic [3:0] gnt_q, gnt_d;
    logic [1:0] owner_q, owner_d;
    logic       busy_q;
    logic [3:0] req;
    logic [1:0] curIdx;
    logic [1:0] probeIdx;
    logic [1:0] winIdx;
    logic       winValid;

    assign req    = {req_3, req_2, req_1, req_0};
    assign curIdx = 2'(state_q - 3'd1);

`ifdef FAIR_ARBITER_TIMEOUT_EN
    localparam logic [3:0] HOLD_LAST = 4'(HOLD_MAX - 1);
    logic [3:0] holdCnt_q, holdCnt_d;
    logic       preempt_q, preempt_d;
    logic       othersReq;

    assign othersReq = |(req & ~(4'b0001 << curIdx));
`endif

    function automatic state_e grantState(input logic [1:0] idx);
        case (idx)
            2'd0:    return GNT0;
            2'd1:    return GNT1;
            2'd2:    return GNT2;
            default: return GNT3;
        endcase
    endfunction

    // Circular search starting just after the most recent winner.
    always_comb begin
        winValid = 1'b0;
        winIdx   = 2'd0;
        probeIdx = 2'd0;
        for (int i = 1; i <= 4; i++) begin
            probeIdx = lastPtr_q + 2'(i);
            if (!winValid && req[probeIdx]) begin
                winValid = 1'b1;
                winIdx   = probeIdx;
            end
        end
    end

    always_comb begin
        state_d   = IDLE;
        lastPtr_d = lastPtr_q;
`ifdef FAIR_ARBITER_TIMEOUT_EN
        holdCnt_d = holdCnt_q;
        preempt_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (winValid) begin
                    state_d   = grantState(winIdx);
                    lastPtr_d = winIdx;
`ifdef FAIR_ARBITER_TIMEOUT_EN
                    holdCnt_d = 4'd0;
`endif
                end
            end
            GNT0, GNT1, GNT2, GNT3: begin
                if (req[curIdx]) begin
                    state_d = grantState(curIdx);
`ifdef FAIR_ARBITER_TIMEOUT_EN
                    if (holdCnt_q == HOLD_LAST && othersReq) begin
                        state_d   = IDLE;
                        preempt_d = 1'b1;
                    end else if (holdCnt_q != 4'hF) begin
                        holdCnt_d = holdCnt_q + 4'd1;
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they leave the flops already aligned with it.
    always_comb begin
        gnt_d   = 4'b0000;
        owner_d = 2'd0;
        case (state_d)
            GNT0:    begin gnt_d = 4'b0001; owner_d = 2'd0; end
            GNT1:    begin gnt_d = 4'b0010; owner_d = 2'd1; end
            GNT2:    begin gnt_d = 4'b0100; owner_d = 2'd2; end
            GNT3:    begin gnt_d = 4'b1000; owner_d = 2'd3; end
            default: begin gnt_d = 4'b0000; owner_d = 2'd0; end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            lastPtr_q <= 2'd3;
            gnt_q     <= 4'b0000;
            owner_q   <= 2'd0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            lastPtr_q <= lastPtr_d;
            gnt_q     <= gnt_d;
            owner_q   <= owner_d;
            busy_q    <= |gnt_d;
        end
    end

`ifdef FAIR_ARBITER_TIMEOUT_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            holdCnt_q <= 4'd0;
            preempt_q <= 1'b0;
        end else begin
            holdCnt_q <= holdCnt_d;
            preempt_q <= preempt_d;
        end
    end

    assign preempt = preempt_q;
`else
    assign preempt = 1'b0;
`endif

    assign gnt_0 = gnt_q[0];
    assign gnt_1 = gnt_q[1];
    assign gnt_2 = gnt_q[2];
    assign gnt_3 = gnt_q[3];
    assign owner = owner_q;
    assign busy  = busy_q;
endmodule

// File: tb/tb_fair_arbiter.sv
// Self-checking bench for fair_arbiter: directed scenarios plus randomized traffic
// compared against a cycle-level reference model of the arbitration rules.
module tb_fair_arbiter;
    localparam int HOLD_MAX = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] req   = 4'b0000;
    logic       gnt_0, gnt_1, gnt_2, gnt_3;
    logic [1:0] owner;
    logic       busy;
    logic       preempt;
    logic [3:0] gntV;

    int errors = 0;
    int checks = 0;

    // Reference model: owner index (-1 when idle), last winner, cycles the grant has lasted.
    int mOwner     = -1;
    int mLast      = 3;
    int mAge       = 0;
    bit mPre       = 1'b0;
    bit mForceIdle = 1'b0;

    fair_arbiter #(.HOLD_MAX(HOLD_MAX)) dut (
        .clock   (clock),
        .reset   (reset),
        .req_0   (req[0]),
        .req_1   (req[1]),
        .req_2   (req[2]),
        .req_3   (req[3]),
        .gnt_0   (gnt_0),
        .gnt_1   (gnt_1),
        .gnt_2   (gnt_2),
        .gnt_3   (gnt_3),
        .owner   (owner),
        .busy    (busy),
        .preempt (preempt)
    );

    assign gntV = {gnt_3, gnt_2, gnt_1, gnt_0};

    always #5 clock = ~clock;

    // Advance the reference model on every rising edge using the levels sampled there.
    always @(posedge clock) begin
        bit found;
        int cand;
        mPre = 1'b0;
        if (reset) begin
            mOwner = -1; mLast = 3; mAge = 0; mForceIdle = 1'b0;
        end else if (mForceIdle) begin
            mOwner = -1; mForceIdle = 1'b0;
        end else if (mOwner < 0) begin
            found = 1'b0;
            for (int k = 1; k <= 4; k++) begin
                cand = (mLast + k) % 4;
                if (!found && req[cand]) begin
                    found = 1'b1; mOwner = cand; mLast = cand; mAge = 1;
                end
            end
        end else if (!req[mOwner]) begin
            mOwner = -1;
        end else begin
`ifdef FAIR_ARBITER_TIMEOUT_EN
            if (mAge == HOLD_MAX && (req & ~(4'b0001 << mOwner)) != 4'b0000) begin
                mOwner = -1; mPre = 1'b1;
            end else begin
                mAge = mAge + 1;
            end
`else
            mAge = mAge + 1;
`endif
        end
    end

    // Two simultaneous grants are never legal, whatever the scenario.
    always @(negedge clock) begin
        checks++;
        if ($countones(gntV) > 1) begin
            errors++;
            $display("[TB] FAIL onehot: gnt=%b, at most one bit may be set", gntV);
        end
    end

    task automatic step;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic pulseReset;
        reset = 1'b1;
        req   = 4'b0000;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        req   = 4'($urandom_range(15));
        step();
        step();
        checks++;
        if ({gntV, owner, busy, preempt} !== 8'b0) begin
            errors++;
            $display("[TB] FAIL reset_state: gnt=%b owner=%0d busy=%b preempt=%b, expected all zero",
                     gntV, owner, busy, preempt);
        end
        reset = 1'b0;
        req   = 4'b0000;
        step();
    endtask

    task automatic test_single_grant;
        pulseReset();
        req = 4'b0100;
        step();
        checks++;
        if (gntV !== 4'b0100 || owner !== 2'd2 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL single_grant: gnt=%b owner=%0d busy=%b, expected 0100/2/1", gntV, owner, busy);
        end
        req = 4'b0000;
        step();
        checks++;
        if (gntV !== 4'b0000 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_release: gnt=%b busy=%b, expected 0000/0", gntV, busy);
        end
    endtask

    task automatic test_rotation;
        int order[$];
        int gaps[$];
        int expOrder[5];
        int held;
        int idleGap;
        expOrder = '{0, 1, 2, 3, 0};
        pulseReset();
        req = 4'b1111;
        held = 0;
        idleGap = 0;
        for (int c = 0; c < 60 && order.size() < 5; c++) begin
            step();
            if (busy === 1'b1) begin
                if (held == 0) begin
                    order.push_back(int'(owner));
                    if (order.size() > 1) gaps.push_back(idleGap);
                end
                held++;
                idleGap = 0;
                if (held == 3) req[owner] = 1'b0;
            end else begin
                held = 0;
                idleGap++;
                req = 4'b1111;
            end
        end
        checks++;
        if (order.size() != 5) begin
            errors++;
            $display("[TB] FAIL rotation_count: saw %0d grants, expected 5", order.size());
        end
        for (int i = 0; i < order.size() && i < 5; i++) begin
            checks++;
            if (order[i] != expOrder[i]) begin
                errors++;
                $display("[TB] FAIL rotation_order[%0d]: owner %0d, expected %0d", i, order[i], expOrder[i]);
            end
        end
        foreach (gaps[i]) begin
            checks++;
            if (gaps[i] != 1) begin
                errors++;
                $display("[TB] FAIL rotation_gap[%0d]: %0d idle cycles, expected 1", i, gaps[i]);
            end
        end
        req = 4'b0000;
        step();
    endtask

    task automatic test_reset_mid_grant;
        pulseReset();
        req = 4'b0010;
        step();
        checks++;
        if (gntV !== 4'b0010 || owner !== 2'd1) begin
            errors++;
            $display("[TB] FAIL mid_reset_grant: gnt=%b owner=%0d, expected 0010/1", gntV, owner);
        end
        reset = 1'b1;
        step();
        checks++;
        if (gntV !== 4'b0000 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_reset_drop: gnt=%b busy=%b, expected 0000/0", gntV, busy);
        end
        reset = 1'b0;
        step();
        checks++;
        if (gntV !== 4'b0010 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mid_reset_regrant: gnt=%b busy=%b, expected 0010/1", gntV, busy);
        end
    endtask

    task automatic test_timeout;
        int hi;
        int preCnt;
        pulseReset();
        req = 4'b1001;
        hi = 0;
        preCnt = 0;
        step();
        for (int c = 0; c < 30 && gntV[0] === 1'b1; c++) begin
            hi++;
            if (preempt === 1'b1) preCnt++;
            step();
        end
`ifdef FAIR_ARBITER_TIMEOUT_EN
        checks++;
        if (hi != HOLD_MAX || preCnt != 0) begin
            errors++;
            $display("[TB] FAIL timeout_hold: gnt_0 high %0d cycles (preempt seen %0d), expected %0d (0)",
                     hi, preCnt, HOLD_MAX);
        end
        checks++;
        if (preempt !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL timeout_pulse: preempt=%b busy=%b, expected 1/0", preempt, busy);
        end
        step();
        checks++;
        if (gntV !== 4'b1000 || preempt !== 1'b0) begin
            errors++;
            $display("[TB] FAIL timeout_next: gnt=%b preempt=%b, expected 1000/0", gntV, preempt);
        end
`else
        checks++;
        if (hi != 30 || preCnt != 0) begin
            errors++;
            $display("[TB] FAIL notimeout_hold: gnt_0 high %0d cycles (preempt seen %0d), expected 30 (0)",
                     hi, preCnt);
        end
        req = 4'b1000;
        step();
        checks++;
        if (gntV !== 4'b0000 || preempt !== 1'b0) begin
            errors++;
            $display("[TB] FAIL notimeout_release: gnt=%b preempt=%b, expected 0000/0", gntV, preempt);
        end
        step();
        checks++;
        if (gntV !== 4'b1000) begin
            errors++;
            $display("[TB] FAIL notimeout_next: gnt=%b, expected 1000", gntV);
        end
`endif
        // A lone requester is never preempted, however long it holds.
        pulseReset();
        req = 4'b0001;
        hi = 0;
        preCnt = 0;
        for (int c = 0; c < 22; c++) begin
            step();
            if (gntV === 4'b0001) hi++;
            if (preempt !== 1'b0) preCnt++;
        end
        checks++;
        if (hi != 22 || preCnt != 0) begin
            errors++;
            $display("[TB] FAIL lone_hold: gnt_0 high %0d of 22 cycles (preempt seen %0d), expected 22 (0)",
                     hi, preCnt);
        end
        req = 4'b0000;
        step();
    endtask

    task automatic test_illegal_state;
        pulseReset();
        req = 4'b0010;
        step();
        checks++;
        if (gntV !== 4'b0010) begin
            errors++;
            $display("[TB] FAIL illegal_setup: gnt=%b, expected 0010", gntV);
        end
        force dut.state_q = 3'b111;
        mForceIdle = 1'b1;
        #2;
        release dut.state_q;
        step();
        checks++;
        if (gntV !== 4'b0000 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL illegal_recover: gnt=%b busy=%b, expected 0000/0", gntV, busy);
        end
        step();
        checks++;
        if (gntV !== 4'b0010 || owner !== 2'd1) begin
            errors++;
            $display("[TB] FAIL illegal_regrant: gnt=%b owner=%0d, expected 0010/1", gntV, owner);
        end
    endtask

    task automatic test_random;
        logic [3:0] expG;
        logic [1:0] expOwner;
        pulseReset();
        for (int c = 0; c < 400; c++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(3) == 0) req[b] = ~req[b];
            end
            reset = ($urandom_range(49) == 0);
            step();
            expG     = (mOwner < 0) ? 4'b0000 : (4'b0001 << mOwner);
            expOwner = (mOwner < 0) ? 2'd0 : 2'(mOwner);
            checks++;
            if ({gntV, owner, busy, preempt} !== {expG, expOwner, (mOwner >= 0), mPre}) begin
                errors++;
                $display("[TB] FAIL random[%0d]: gnt=%b owner=%0d busy=%b preempt=%b, expected %b/%0d/%b/%b",
                         c, gntV, owner, busy, preempt, expG, expOwner, (mOwner >= 0), mPre);
            end
        end
        reset = 1'b0;
        req   = 4'b0000;
        step();
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_single_grant();
        test_rotation();
        test_reset_mid_grant();
        test_timeout();
        test_illegal_state();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
